// File: rtl/conv_16_pkg.sv
// conv_16_pkg: shared constants and the requantise helper for the conv_16 datapath.
//   Default widths for product, bias, accumulator and output words.
//   requantise(): round-half-up arithmetic right shift, saturation to a signed
//   out_w-bit range and optional ReLU. It also reports whether saturation clipped.
package conv_16_pkg;

  localparam int unsigned PROD_W = 24;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned OUT_W  = 16;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } requant_t;

  // The work is done at 64 bits so one function serves every layer width.
  function automatic requant_t requantise(input logic signed [63:0] sum,
                                          input int unsigned        shift,
                                          input int unsigned        out_w,
                                          input logic               relu);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    requant_t           res;
    r  = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.sat = 1'b0;
    if (r > hi) begin
      r       = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      r       = lo;
      res.sat = 1'b1;
    end
    // ReLU clipping is intentional and is not reported as saturation.
    if (relu && (r < 64'sd0)) r = '0;
    res.value = r;
    return res;
  endfunction

endpackage

// File: rtl/conv_16_requant.sv
// conv_16_requant: combinational path from a finished window sum to the output word.
//   sum  - signed accumulator value, bias already included
//   dout - rounded, saturated and optionally ReLU-clamped result
//   sat  - high when saturation clipped the result
module conv_16_requant
  import conv_16_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_W,
  parameter int unsigned OUT_WIDTH = OUT_W,
  parameter int unsigned SHIFT     = 7,
  parameter int unsigned RELU_EN   = 1
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  requant_t rq;
  logic     unused_hi;

  always_comb begin
    rq   = requantise(64'(sum), SHIFT, OUT_WIDTH, RELU_EN != 0);
    dout = rq.value[OUT_WIDTH-1:0];
    sat  = rq.sat;
  end

  // Saturation guarantees the upper bits are a pure sign extension.
  assign unused_hi = ^rq.value[63:OUT_WIDTH];

endmodule

// File: rtl/conv_16_acc_requant.sv
// conv_16_acc_requant: accumulates KERNEL_LEN signed products per output pixel,
// adds a per-window bias and requantises to OUT_WIDTH bits.
//   ap_clk, ap_rst_n       - clock, async active-low reset
//   acc_clr                - synchronous abort of the partial window (wins over a product)
//   prod_din/bias_din      - product and bias (bias sampled with the first tap only)
//   prod_valid/prod_ready  - product handshake; only the final tap can stall
//   dout/dout_valid/ready  - registered result handshake
//   sat_flag               - sticky saturation indicator, cleared by reset or acc_clr
module conv_16_acc_requant
  import conv_16_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = PROD_W,
  parameter int unsigned BIAS_WIDTH = BIAS_W,
  parameter int unsigned ACC_WIDTH  = ACC_W,
  parameter int unsigned OUT_WIDTH  = OUT_W,
  parameter int unsigned KERNEL_LEN = 9,
  parameter int unsigned SHIFT      = 7,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         acc_clr,
  input  logic signed [PROD_WIDTH-1:0] prod_din,
  input  logic signed [BIAS_WIDTH-1:0] bias_din,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  output logic signed [OUT_WIDTH-1:0]  dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         sat_flag
);

  localparam int unsigned      CntW    = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(KERNEL_LEN - 1);

  logic [CntW-1:0]              cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         sat_q, sat_d;

  logic                         first_tap, last_tap, accept, load;
  logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext, sum;
  logic signed [OUT_WIDTH-1:0]  rq_dout;
  logic                         rq_sat;

  assign first_tap = (cnt_q == '0);
  assign last_tap  = (cnt_q == LastCnt);

  // Only the final tap waits for room in the output register.
  assign prod_ready = !last_tap || !dout_valid_q || dout_ready;
  assign accept     = prod_valid && prod_ready && !acc_clr;
  assign load       = accept && last_tap;

  assign prod_ext = ACC_WIDTH'(prod_din);
  // Bias shares the output fixed-point format, so align it to the product scale.
  assign bias_ext = ACC_WIDTH'(bias_din) <<< SHIFT;
  assign sum      = acc_q + prod_ext;

  conv_16_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU_EN   (RELU_EN)
  ) u_requant (
    .sum  (sum),
    .dout (rq_dout),
    .sat  (rq_sat)
  );

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    sat_d = sat_q;
    if (acc_clr) begin
      cnt_d = '0;
      acc_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      if (last_tap) begin
        cnt_d = '0;
        sat_d = sat_q | rq_sat;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = first_tap ? (bias_ext + prod_ext) : sum;
      end
    end
    dout_d       = load ? rq_dout : dout_q;
    // A drain and a load in the same cycle keeps the register full.
    dout_valid_d = load | (dout_valid_q & ~dout_ready);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat_flag   = sat_q;

endmodule
